// File: rtl/game_pkg.sv
// Shared types for the 2048 game controllers: movement codes from the button FSM
// and the move sequencer state encoding.
package game_pkg;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      IZQUIERDA = 3'd1,
      DERECHA   = 3'd2,
      ARRIBA    = 3'd3,
      ABAJO     = 3'd4
   } move_t;

   typedef enum logic [2:0] {
      IDLE,
      LINE,
      SPAWN,
      CHECK,
      WON,
      OVER
   } seq_state_t;

   localparam int N_LINES_DEF = 4;

   // Codes 5-7 are unused encodings and are treated like NONE.
   function automatic logic is_move(input logic [2:0] code);
      return (code >= 3'd1) && (code <= 3'd4);
   endfunction

endpackage

// File: rtl/move_edge.sv
// Turns a level movement code into single accepted moves: a move is offered only
// after the buttons have been released (movement returned to NONE) since the last accept.
module move_edge
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] movement,
   input  logic       accept,
   output logic       move_valid,
   output move_t      move_code
);

   logic armed;

   // NOTE: registers are assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         armed <= 1'b0;
      else if (movement == NONE)
         armed <= 1'b1;
      else if (accept)
         armed <= 1'b0;
   end

   assign move_valid = armed && is_move(movement);
   assign move_code  = move_t'(movement);

endmodule

// File: rtl/move_sequencer.sv
// Runs one accepted move as N_LINES line requests on the merge datapath, then
// spawns a tile if anything changed, accumulates score and checks for end of game.
module move_sequencer
   import game_pkg::*;
#(
   parameter int N_LINES = N_LINES_DEF,
   parameter int PTS_W   = 12,
   parameter int SCORE_W = 16,
   parameter int MOVES_W = 10,
   localparam int IDX_W  = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         movement,
   output logic               line_req,
   input  logic               line_ack,
   output logic [IDX_W-1:0]   line_idx,
   output logic [2:0]         line_dir,
   input  logic               line_changed,
   input  logic [PTS_W-1:0]   line_points,
   output logic               spawn_req,
   input  logic               spawn_ack,
   input  logic               board_has_2048,
   input  logic               board_can_move,
   output logic               busy,
   output logic [SCORE_W-1:0] score,
   output logic [MOVES_W-1:0] moves,
   output logic               game_won,
   output logic               game_over
);

   seq_state_t         state;
   logic               chg_any;
   logic               move_valid;
   move_t              move_code;
   logic               accept;
   logic               last_line;
   logic               chg_now;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_sat;

   assign accept    = move_valid && (state == IDLE);
   assign last_line = (line_idx == IDX_W'(N_LINES - 1));
   assign chg_now   = chg_any | line_changed;

   // One extra bit catches the carry so the score clamps at all-ones.
   assign score_sum = {1'b0, score} + (SCORE_W + 1)'(line_points);
   assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

   move_edge u_move_edge (
      .clk        (clk),
      .rst        (rst),
      .movement   (movement),
      .accept     (accept),
      .move_valid (move_valid),
      .move_code  (move_code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         chg_any   <= 1'b0;
         line_req  <= 1'b0;
         line_idx  <= '0;
         line_dir  <= '0;
         spawn_req <= 1'b0;
         busy      <= 1'b0;
         score     <= '0;
         moves     <= '0;
         game_won  <= 1'b0;
         game_over <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  line_dir <= move_code;
                  line_idx <= '0;
                  chg_any  <= 1'b0;
                  line_req <= 1'b1;
                  busy     <= 1'b1;
                  state    <= LINE;
               end
            end
            LINE: begin
               // Each ack consumes exactly one request; line_req stays up between lines.
               if (line_ack) begin
                  score   <= score_sat;
                  chg_any <= chg_now;
                  if (last_line) begin
                     line_req <= 1'b0;
                     if (chg_now) begin
                        spawn_req <= 1'b1;
                        state     <= SPAWN;
                     end else begin
                        state <= CHECK;
                     end
                  end else begin
                     line_idx <= line_idx + 1'b1;
                  end
               end
            end
            SPAWN: begin
               if (spawn_ack) begin
                  spawn_req <= 1'b0;
                  moves     <= moves + 1'b1;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               busy <= 1'b0;
               if (board_has_2048) begin
                  game_won <= 1'b1;
                  state    <= WON;
               end else if (!board_can_move) begin
                  game_over <= 1'b1;
                  state     <= OVER;
               end else begin
                  state <= IDLE;
               end
            end
            WON, OVER: state <= state;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: drives whole moves through a small datapath
// responder and compares cycle counts, handshakes and counters against hand values.
module tb_move_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  movement;
   logic        line_req;
   logic        line_ack;
   logic [1:0]  line_idx;
   logic [2:0]  line_dir;
   logic        line_changed;
   logic [11:0] line_points;
   logic        spawn_req;
   logic        spawn_ack;
   logic        board_has_2048;
   logic        board_can_move;
   logic        busy;
   logic [15:0] score;
   logic [9:0]  moves;
   logic        game_won;
   logic        game_over;

   int total = 0;
   int bad   = 0;

   int busy_cnt, req_cnt, spawn_cnt, hs_cnt, idx_bad, dir_bad, stable_bad, wcnt;
   logic        prev_pending;
   logic [1:0]  prev_idx;

   move_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .movement       (movement),
      .line_req       (line_req),
      .line_ack       (line_ack),
      .line_idx       (line_idx),
      .line_dir       (line_dir),
      .line_changed   (line_changed),
      .line_points    (line_points),
      .spawn_req      (spawn_req),
      .spawn_ack      (spawn_ack),
      .board_has_2048 (board_has_2048),
      .board_can_move (board_can_move),
      .busy           (busy),
      .score          (score),
      .moves          (moves),
      .game_won       (game_won),
      .game_over      (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arms with movement=0, presents code and holds it for `hold` cycles while acting
   // as the datapath: acks each line after `delay` waiting cycles, points per line index.
   task automatic run_move(input logic [2:0] code, input logic chg,
                           input logic [3:0][11:0] pts, input int delay, input int hold);
      movement = 3'd0;
      line_ack = 1'b0;
      tick();
      busy_cnt = 0; req_cnt = 0; spawn_cnt = 0; hs_cnt = 0;
      idx_bad = 0; dir_bad = 0; stable_bad = 0; wcnt = 0;
      prev_pending = 1'b0;
      prev_idx     = '0;
      movement     = code;
      line_changed = chg;
      line_ack     = (delay == 0);
      for (int t = 0; t < hold; t++) begin
         tick();
         if (delay == 0) begin
            line_ack = 1'b1;
         end else if (line_req) begin
            wcnt++;
            line_ack = (wcnt == delay + 1);
            if (line_ack) wcnt = 0;
         end else begin
            line_ack = 1'b0;
         end
         line_points = pts[line_idx];
         if (prev_pending && (!line_req || line_idx != prev_idx)) stable_bad++;
         if (busy) busy_cnt++;
         if (spawn_req) spawn_cnt++;
         if (line_req) begin
            req_cnt++;
            if (line_dir != code) dir_bad++;
            if (line_ack) begin
               if (int'(line_idx) != hs_cnt) idx_bad++;
               hs_cnt++;
            end
         end
         prev_pending = line_req && !line_ack;
         prev_idx     = line_idx;
      end
      movement = 3'd0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      movement       = 3'd0;
      line_ack       = 1'b1;
      line_changed   = 1'b1;
      line_points    = 12'd0;
      spawn_ack      = 1'b1;
      board_has_2048 = 1'b0;
      board_can_move = 1'b1;
      tick();
      tick();
      check("rst_ctrl", {line_req, spawn_req, busy, game_won, game_over}, 0);
      check("rst_score", score, 0);
      check("rst_moves", moves, 0);
      check("rst_idx_dir", {line_idx, line_dir}, 0);
      rst = 1'b0;

      // Changed move held 20 cycles: exactly one sequence.
      run_move(3'd1, 1'b1, {12'd4, 12'd4, 12'd4, 12'd4}, 0, 20);
      check("t1_busy", busy_cnt, 6);
      check("t1_req", req_cnt, 4);
      check("t1_hs", hs_cnt, 4);
      check("t1_idx", idx_bad, 0);
      check("t1_dir", dir_bad, 0);
      check("t1_spawn", spawn_cnt, 1);
      check("t1_score", score, 16);
      check("t1_moves", moves, 1);
      check("t1_idle", busy, 0);

      // Unchanged move: no spawn, no move count.
      run_move(3'd3, 1'b0, '0, 0, 15);
      check("t2_busy", busy_cnt, 5);
      check("t2_spawn", spawn_cnt, 0);
      check("t2_moves", moves, 1);
      check("t2_dir", dir_bad, 0);
      check("t2_score", score, 16);

      // Slow datapath: 3 wait cycles per line.
      run_move(3'd2, 1'b1, {12'd1, 12'd1, 12'd1, 12'd1}, 3, 30);
      check("t3_req", req_cnt, 16);
      check("t3_hs", hs_cnt, 4);
      check("t3_stable", stable_bad, 0);
      check("t3_idx", idx_bad, 0);
      check("t3_busy", busy_cnt, 18);
      check("t3_spawn", spawn_cnt, 1);
      check("t3_score", score, 20);
      check("t3_moves", moves, 2);

      // Climb to 0xFFFE, then saturate.
      for (int i = 0; i < 3; i++)
         run_move(3'd4, 1'b0, {12'd4095, 12'd4095, 12'd4095, 12'd4095}, 0, 12);
      run_move(3'd4, 1'b0, {12'd4089, 12'd4095, 12'd4095, 12'd4095}, 0, 12);
      check("t4_near", score, 16'hFFFE);
      run_move(3'd1, 1'b0, {12'd0, 12'd0, 12'd0, 12'd8}, 0, 12);
      check("t4_sat", score, 16'hFFFF);
      run_move(3'd2, 1'b0, {12'd4095, 12'd4095, 12'd4095, 12'd4095}, 0, 12);
      check("t4_hold", score, 16'hFFFF);
      check("t4_moves", moves, 2);

      // Win beats game over; terminal state ignores moves.
      board_has_2048 = 1'b1;
      board_can_move = 1'b0;
      run_move(3'd4, 1'b1, '0, 0, 12);
      check("t5_won", {game_won, game_over}, 2'b10);
      check("t5_moves", moves, 3);
      run_move(3'd1, 1'b1, {12'd4, 12'd4, 12'd4, 12'd4}, 0, 12);
      check("t5_ignored", busy_cnt, 0);
      check("t5_frozen", {moves, score}, {10'd3, 16'hFFFF});
      pulse_rst();
      check("t5_rst", {game_won, game_over, score}, 0);

      // Loss path.
      board_has_2048 = 1'b0;
      run_move(3'd1, 1'b0, {12'd2, 12'd2, 12'd2, 12'd2}, 0, 12);
      check("t5_over", {game_won, game_over}, 2'b01);
      check("t5_over_score", score, 8);
      board_can_move = 1'b1;
      pulse_rst();

      // Reset while a line request waits for its ack.
      tick();
      movement = 3'd2;
      line_ack = 1'b0;
      tick();
      tick();
      check("t6_req", {line_req, busy}, 2'b11);
      rst = 1'b1;
      tick();
      check("t6_abort", {line_req, spawn_req, busy, line_idx, line_dir}, 0);
      rst      = 1'b0;
      line_ack = 1'b1;
      busy_cnt = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (busy) busy_cnt++;
      end
      check("t6_no_repeat", busy_cnt, 0);
      movement = 3'd0;
      tick();
      movement = 3'd2;
      tick();
      check("t6_rearm", {busy, line_req, line_dir}, {2'b11, 3'd2});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
